mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-port, variable-latency backing memory between the instruction-fetch requester (I, read-only) and the data-access requester (D, read/write) of the pipelined RISC-V CPU.
- Uses a req/ack handshake on both sides, round-robin tie-breaking and a watchdog timeout.
- Sits between the IF/MEM stages and the memory model; the hazard unit stalls a stage while its req is high and its ack is not yet seen.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, max BUSY cycles waiting for mem_ack_i; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- i_req_i  in  1  fetch request; held until i_ack_o is seen.
- i_addr_i  in  ADDR_W  fetch address.
- i_ack_o  out  1  one-cycle completion pulse.
- i_rdata_o  out  DATA_W  fetch data; valid while i_ack_o is high.
- i_err_o  out  1  timeout flag; valid while i_ack_o is high.
- d_req_i  in  1  data request; held until d_ack_o is seen.
- d_we_i  in  1  1 = write.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  write data.
- d_ack_o  out  1  one-cycle completion pulse.
- d_rdata_o  out  DATA_W  read data; 0 on write or error.
- d_err_o  out  1  timeout flag.
- mem_req_o  out  1  memory request, level.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_ack_i  in  1  memory completion, one cycle.
- mem_rdata_i  in  DATA_W  valid with mem_ack_i.
- busy_o  out  1  high in BUSY_I, BUSY_D, DONE.

Behaviour:
- All outputs are registered.
- Reset (rst_i==0 at a clock edge):
  - state=IDLE, last_grant=GNT_I.
  - All ack/err/req/we outputs 0; all data/address outputs 0.
  - Takes effect regardless of state.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - Only d_req_i high: go to BUSY_D.
  - Only i_req_i high: go to BUSY_I.
  - Both high: grant the requester != last_grant.
  - On grant: latch addr/we/wdata into mem_*_o, set mem_req_o=1 and last_grant, clear the watchdog.
  - For I grants, mem_we_o=0.
- BUSY_x:
  - mem_req_o and mem_*_o stay stable.
  - mem_ack_i==1: go to DONE; x_rdata_o = mem_rdata_i for reads, 0 for writes; x_err_o=0.
  - Else, if TIMEOUT!=0 and the watchdog count reaches TIMEOUT-1: go to DONE with x_err_o=1, x_rdata_o=0.
  - Else increment the watchdog.
  - mem_ack_i in the expiry cycle wins (no error).
- DONE:
  - x_ack_o=1 for exactly this cycle; mem_req_o=0.
  - Next state is IDLE unconditionally.
- Latency:
  - Request sampled in cycle N: mem_req_o high from N+1.
  - mem_ack_i sampled in cycle M ≥ N+1: x_ack_o high in M+1, mem_req_o low in M+1, IDLE in M+2.
  - Minimum request-to-ack is 2 cycles; minimum spacing between acks is 3 cycles.
- Requester rule: req drops in the cycle after ack (or combinationally during ack). IDLE never re-grants a completed request.
- mem_ack_i outside BUSY_x (late ack after reset or after a timeout) is ignored, with no output effect.
- Addr/data changes on a held req after grant are ignored until the next grant.
- Never both i_ack_o and d_ack_o in the same cycle; never both i_err_o and d_err_o.
- Watchdog width is $clog2(TIMEOUT+1), minimum 1. Saturates; no wrap.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY_I, BUSY_D, DONE}.
  - grant enum {GNT_I=0, GNT_D=1}.
  - Default widths.
- One sub-module, mem_arb_wdt:
  - Inputs: clear, enable.
  - Output: expire.
  - Parameter TIMEOUT.
  - Synchronous active-low reset on rst_i.

Test Plan:
1. i_req_i=1, i_addr_i=0x4 in cycle 0; mem_ack_i in cycle 3 with 0x00A00093 → mem_req_o=1 in cycles 1–3, mem_addr_o=0x4; i_ack_o=1 and i_rdata_o=0x00A00093 in cycle 4 only; busy_o=0 in cycle 5.
2. After reset, i_req_i and d_req_i rise together; D write addr 0x10, data 0x55 → D granted first with mem_we_o=1, mem_wdata_o=0x55; d_ack_o with d_rdata_o=0; then I granted.
3. Both reqs held high continuously, memory latency 1 → grant order D, I, D, I; acks every 3 cycles; never coincident.
4. TIMEOUT=8, D read at cycle 0, no mem_ack_i → BUSY cycles 1–8; d_ack_o=d_err_o=1 in cycle 9, d_rdata_o=0; stale mem_ack_i in cycle 12 → no response.
5. rst_i=0 in cycle 2 during BUSY_I → cycle 3 has mem_req_o=0 and busy_o=0; mem_ack_i in cycle 4 → no i_ack_o; a new i_req_i is served normally.
6. mem_ack_i asserted in the first BUSY cycle (zero memory latency) → ack 2 cycles after the request; same-cycle ack on the TIMEOUT expiry cycle → err=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared states, grant encoding and default widths for the memory port arbiter.
package mem_arb_pkg;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;
    typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} grant_e;

    function automatic int wdt_width(input int timeout);
        return timeout == 0 ? 1 : $clog2(timeout + 1);
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory handshake signals of the arbiter.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              i_req_i, i_ack_o, i_err_o;
    logic [ADDR_W-1:0] i_addr_i;
    logic [DATA_W-1:0] i_rdata_o;
    logic              d_req_i, d_we_i, d_ack_o, d_err_o;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i, d_rdata_o;
    logic              mem_req_o, mem_we_o, mem_ack_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;
    logic              busy_o;

    modport slave (
        input  i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_ack_i, mem_rdata_i,
        output i_ack_o, i_rdata_o, i_err_o, d_ack_o, d_rdata_o, d_err_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
    );
    modport master (
        output i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_ack_i, mem_rdata_i,
        input  i_ack_o, i_rdata_o, i_err_o, d_ack_o, d_rdata_o, d_err_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter_wdt.sv
// mem_arb_wdt: saturating watchdog counting stalled BUSY cycles; expire flags the last allowed one.
module mem_arb_wdt
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = wdt_width(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i || clear) r_cnt <= '0;
        else if (enable && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end

    assign expire = TIMEOUT != 0 && r_cnt == LAST;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbitration of one variable-latency memory between fetch (I) and data (D).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_port_arbiter_if.slave  bus
);
    state_e            r_state;
    grant_e            r_last;
    logic              w_gnt_d, w_expire;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_rdata;

    // On a tie the requester that was not served last wins.
    assign w_gnt_d = bus.d_req_i && (!bus.i_req_i || r_last == GNT_I);
    assign w_addr  = w_gnt_d ? bus.d_addr_i : bus.i_addr_i;
    assign w_rdata = bus.mem_we_o ? '0 : bus.mem_rdata_i;

    mem_arb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (r_state == IDLE),
        .enable ((r_state == BUSY_I || r_state == BUSY_D) && !bus.mem_ack_i),
        .expire (w_expire)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state         <= IDLE;
            r_last          <= GNT_I;
            bus.i_ack_o     <= 1'b0;
            bus.i_err_o     <= 1'b0;
            bus.i_rdata_o   <= '0;
            bus.d_ack_o     <= 1'b0;
            bus.d_err_o     <= 1'b0;
            bus.d_rdata_o   <= '0;
            bus.mem_req_o   <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            bus.busy_o      <= 1'b0;
        end else begin
            bus.i_ack_o <= 1'b0;
            bus.i_err_o <= 1'b0;
            bus.d_ack_o <= 1'b0;
            bus.d_err_o <= 1'b0;
            case (r_state)
                IDLE: if (bus.i_req_i || bus.d_req_i) begin
                    r_state         <= w_gnt_d ? BUSY_D : BUSY_I;
                    r_last          <= w_gnt_d ? GNT_D : GNT_I;
                    bus.mem_req_o   <= 1'b1;
                    bus.mem_we_o    <= w_gnt_d && bus.d_we_i;
                    bus.mem_addr_o  <= w_addr;
                    bus.mem_wdata_o <= w_gnt_d ? bus.d_wdata_i : '0;
                    bus.busy_o      <= 1'b1;
                end
                // A memory ack in the expiry cycle takes priority over the timeout.
                BUSY_I, BUSY_D: if (bus.mem_ack_i || w_expire) begin
                    r_state       <= DONE;
                    bus.mem_req_o <= 1'b0;
                    if (r_state == BUSY_D) begin
                        bus.d_ack_o   <= 1'b1;
                        bus.d_err_o   <= !bus.mem_ack_i;
                        bus.d_rdata_o <= bus.mem_ack_i ? w_rdata : '0;
                    end else begin
                        bus.i_ack_o   <= 1'b1;
                        bus.i_err_o   <= !bus.mem_ack_i;
                        bus.i_rdata_o <= bus.mem_ack_i ? w_rdata : '0;
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    bus.busy_o <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
